// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes and
// architectural carry/zero flags.
//
// Stage S1 captures the offered operation (opcode, operands, tag).
// Stage S2 holds the executed result until the consumer takes it.
// Execution happens as the operation moves from S1 into S2, so it always
// sees the flags written by every older operation.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       synchronous clear of both stages (flags kept)
//   in_valid   in   1       operation offered on in_*
//   in_ready   out  1       operation accepted this cycle when in_valid=1
//   in_op      in   3       opcode (see op_e)
//   in_a       in   WIDTH   operand A
//   in_b       in   WIDTH   operand B
//   in_tag     in   TAG_W   opaque tag, returned with the result
//   out_valid  out  1       result presented on out_*
//   out_ready  in   1       consumer takes the result this cycle
//   out_data   out  WIDTH   result (0 when the operation was skipped)
//   out_tag    out  TAG_W   tag of the presented result
//   out_skip   out  1       conditional operation was not executed
//   c_flag     out  1       architectural carry flag (1 = no borrow on SUB)
//   z_flag     out  1       architectural zero flag
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_skip,
    output logic             c_flag,
    output logic             z_flag
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,   // a + b
        OP_ADC  = 3'b001,   // a + b, only if C=1
        OP_ADZ  = 3'b010,   // a + b, only if Z=1
        OP_SUB  = 3'b011,   // a + ~b + 1
        OP_NAND = 3'b100,   // ~(a & b)
        OP_NDC  = 3'b101,   // ~(a & b), only if C=1
        OP_NDZ  = 3'b110,   // ~(a & b), only if Z=1
        OP_PASS = 3'b111    // b
    } op_e;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic move;     // S1 contents advance into S2 at this edge
    logic accept;   // offered operation is captured into S1 at this edge

    // S1 may advance when S2 is empty or is being drained this cycle.
    assign move     = s1_valid && (!s2_valid || out_ready);
    // in_ready never looks at in_valid, so the producer can use it freely.
    assign in_ready = !flush && (!s1_valid || move);
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;

    // -----------------------------------------------------------------------
    // Execute (combinational, consumes S1 and the current flags)
    // -----------------------------------------------------------------------
    logic             ex_cond;
    logic             ex_is_arith;
    logic             ex_is_nand;
    logic [WIDTH-1:0] ex_b_op;
    logic             ex_cin;
    logic [WIDTH:0]   ex_sum;
    logic [WIDTH-1:0] ex_data;
    logic             ex_skip;
    logic             ex_c;
    logic             ex_z;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the case statements can leave it unassigned (no latch).
    always_comb begin
        ex_cond     = 1'b1;
        ex_is_arith = 1'b0;
        ex_is_nand  = 1'b0;
        ex_b_op     = s1_b;
        ex_cin      = 1'b0;
        ex_sum      = '0;
        ex_data     = '0;
        ex_skip     = 1'b0;
        ex_c        = c_flag;
        ex_z        = z_flag;

        unique case (s1_op)
            OP_ADD:  ex_is_arith = 1'b1;
            OP_ADC: begin
                ex_is_arith = 1'b1;
                ex_cond     = c_flag;
            end
            OP_ADZ: begin
                ex_is_arith = 1'b1;
                ex_cond     = z_flag;
            end
            OP_SUB: begin
                // Two's-complement subtract: carry out of the top bit
                // means no borrow occurred.
                ex_is_arith = 1'b1;
                ex_b_op     = ~s1_b;
                ex_cin      = 1'b1;
            end
            OP_NAND: ex_is_nand = 1'b1;
            OP_NDC: begin
                ex_is_nand = 1'b1;
                ex_cond    = c_flag;
            end
            OP_NDZ: begin
                ex_is_nand = 1'b1;
                ex_cond    = z_flag;
            end
            OP_PASS: ;
        endcase

        ex_sum = {1'b0, s1_a} + {1'b0, ex_b_op} + {{WIDTH{1'b0}}, ex_cin};

        if (!ex_cond) begin
            // Skipped: zero result, flags untouched, slot still occupied.
            ex_skip = 1'b1;
            ex_data = '0;
        end else if (ex_is_arith) begin
            ex_data = ex_sum[WIDTH-1:0];
            ex_c    = ex_sum[WIDTH];
            ex_z    = (ex_sum[WIDTH-1:0] == '0);
        end else if (ex_is_nand) begin
            ex_data = ~(s1_a & s1_b);
            ex_z    = ((~(s1_a & s1_b)) == '0);
        end else begin
            // PASS: result is operand B, no flag is written.
            ex_data = s1_b;
        end
    end

    // -----------------------------------------------------------------------
    // S1: operand register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            // Also covers accept-and-move in the same cycle: S1 refills.
            s1_valid <= 1'b1;
            s1_op    <= op_e'(in_op);
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
        end else if (move) begin
            s1_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // S2: result register and architectural flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_skip <= 1'b0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
        end else if (flush) begin
            // Flush wins over any move: the S1 operation never executes,
            // so the flags keep their current values.
            s2_valid <= 1'b0;
        end else if (move) begin
            s2_valid <= 1'b1;
            out_data <= ex_data;
            out_tag  <= s1_tag;
            out_skip <= ex_skip;
            c_flag   <= ex_c;
            z_flag   <= ex_z;
        end else if (out_ready) begin
            // Drained with nothing behind it; payload is left as is.
            s2_valid <= 1'b0;
        end
    end

endmodule
